// File: rtl/frv_core_fetch_requester_pkg.sv
// Shared types and constants for the fetch requester.
package frv_core_fetch_requester_pkg;

    localparam int unsigned XL = 31;
    localparam logic [XL:0] FRV_PC_RESET_VALUE_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        FS_RESET,
        FS_RUN,
        FS_DRAIN,
        FS_HALT
    } fetch_state_t;

endpackage

// File: rtl/frv_core_fetch_requester_if.sv
// Redirect, instruction-memory and fetch-buffer signals of the fetch requester.
interface frv_core_fetch_requester_if;
    import frv_core_fetch_requester_pkg::*;

    logic          cf_req;
    logic [XL:0]   cf_target;
    logic          cf_ack;
    logic          imem_req;
    logic [XL:0]   imem_addr;
    logic          imem_gnt;
    logic          imem_recv;
    logic          imem_ack;
    logic          imem_error;
    logic [XL:0]   imem_rdata;
    logic          f_4byte;
    logic          f_2byte;
    logic          f_err;
    logic [XL:0]   f_in;
    logic          f_ready;
    logic          buf_flush;

    modport master (
        input  cf_req, cf_target, imem_gnt, imem_recv, imem_error, imem_rdata, f_ready,
        output cf_ack, imem_req, imem_addr, imem_ack, f_4byte, f_2byte, f_err, f_in, buf_flush
    );

    modport slave (
        output cf_req, cf_target, imem_gnt, imem_recv, imem_error, imem_rdata, f_ready,
        input  cf_ack, imem_req, imem_addr, imem_ack, f_4byte, f_2byte, f_err, f_in, buf_flush
    );

endinterface

// File: rtl/frv_core_fetch_requester.sv
// Fetch-stage requester: issues word reads, tracks outstanding responses and handles redirects.
// Optional FRV_FETCH_ERR_HALT_EN: stop issuing after a bus error until the next redirect.
module frv_core_fetch_requester
    import frv_core_fetch_requester_pkg::*;
#(
    parameter logic [XL:0] FRV_PC_RESET_VALUE = FRV_PC_RESET_VALUE_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING    = 2
) (
    input logic                         g_clk,
    input logic                         g_resetn,
    frv_core_fetch_requester_if.master  bus
);

    localparam int unsigned CntW = 2;

    fetch_state_t               state_q, state_d;
    logic [XL:2]                fetch_addr_q, fetch_addr_d;
    logic                       half_first_q, half_first_d;
    logic [CntW-1:0]            outstanding_q, outstanding_d;
    logic [CntW-1:0]            drop_q, drop_d;
    logic [MAX_OUTSTANDING-1:0] hf_fifo_q, hf_fifo_d;
    logic                       pend_q, pend_d;

    logic            can_issue, gnt, stale_resp, consume, deliver, err_halt;
    logic [CntW-1:0] stale_cnt, push_idx;
    logic [XL:0]     next_addr;

    logic unused_cf_target_lsb;
    assign unused_cf_target_lsb = bus.cf_target[0];

    always_comb begin
        can_issue = (state_q == FS_RUN) && (drop_q == '0) &&
                    (outstanding_q < CntW'(MAX_OUTSTANDING));
        // A raised request is held until granted, even if halting in the meantime.
        bus.imem_req  = can_issue | pend_q;
        bus.imem_addr = {fetch_addr_q, 2'b00};
        gnt           = bus.imem_req & bus.imem_gnt;
        bus.cf_ack    = bus.cf_req & ~(bus.imem_req & ~bus.imem_gnt);
        bus.buf_flush = bus.cf_ack;

        stale_resp    = (drop_q != '0);
        bus.imem_ack  = stale_resp | bus.f_ready;
        consume       = bus.imem_recv & bus.imem_ack;
        deliver       = consume & ~stale_resp & ~bus.cf_ack;
        bus.f_4byte   = deliver & ~hf_fifo_q[0];
        bus.f_2byte   = deliver & hf_fifo_q[0];
        bus.f_err     = deliver & bus.imem_error;
        bus.f_in      = bus.imem_rdata;

`ifdef FRV_FETCH_ERR_HALT_EN
        err_halt      = deliver & bus.imem_error;
`else
        err_halt      = 1'b0;
`endif

        stale_cnt     = outstanding_q + CntW'(gnt) - CntW'(consume);
        outstanding_d = stale_cnt;
        push_idx      = outstanding_q - CntW'(consume);
        next_addr     = bus.imem_addr + (XL+1)'(4);
        pend_d        = bus.imem_req & ~bus.imem_gnt;

        hf_fifo_d = consume ? (hf_fifo_q >> 1) : hf_fifo_q;
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (gnt && (CntW'(i) == push_idx)) hf_fifo_d[i] = half_first_q;
        end

        fetch_addr_d = fetch_addr_q;
        half_first_d = half_first_q;
        drop_d       = drop_q;
        if (bus.cf_ack) begin
            fetch_addr_d = bus.cf_target[XL:2];
            half_first_d = bus.cf_target[1];
            drop_d       = stale_cnt;
        end else begin
            if (gnt) begin
                fetch_addr_d = next_addr[XL:2];
                half_first_d = 1'b0;
            end
            if (consume && stale_resp) drop_d = drop_q - 1'b1;
        end

        state_d = state_q;
        if (bus.cf_ack) begin
            state_d = (stale_cnt != '0) ? FS_DRAIN : FS_RUN;
        end else begin
            case (state_q)
                FS_RESET: state_d = FS_RUN;
                FS_RUN:   if (err_halt) state_d = FS_HALT;
                FS_DRAIN: if (drop_d == '0) state_d = FS_RUN;
                FS_HALT:  state_d = FS_HALT;
                default:  state_d = FS_RESET;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q       <= FS_RESET;
            fetch_addr_q  <= FRV_PC_RESET_VALUE[XL:2];
            half_first_q  <= FRV_PC_RESET_VALUE[1];
            outstanding_q <= '0;
            drop_q        <= '0;
            hf_fifo_q     <= '0;
            pend_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            half_first_q  <= half_first_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            hf_fifo_q     <= hf_fifo_d;
            pend_q        <= pend_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_resetn && bus.imem_recv) begin
            assert (outstanding_q != '0) else $error("imem_recv with no outstanding read");
        end
    end

endmodule
